// File: rtl/data_memory_arbiter_pkg.sv
// ============================================================================
// Module      : data_memory_arbiter_pkg
// Description : Shared definitions for the data_memory arbiter slice:
//               data_memory access-size codes, requester port identifiers
//               and the lock FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_arbiter_pkg;

  // Access size codes understood by data_memory (mem_mode).
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_mode_e;

  // Requester identifiers; also used to remember the last owner and the
  // port an outstanding read response belongs to.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Lock FSM: IDLE arbitrates round-robin, LOCK_x keeps port x as owner.
  typedef enum logic [1:0] {
    LOCK_IDLE = 2'd0,
    LOCK_A    = 2'd1,
    LOCK_B    = 2'd2
  } lock_state_e;

endpackage : data_memory_arbiter_pkg

`default_nettype wire

// File: rtl/data_memory_rr_pick.sv
// ============================================================================
// Module      : data_memory_rr_pick
// Description : Combinational two-way round-robin picker. A lone requester
//               wins; on a tie the port that did not own the memory last
//               wins.
// Ports       : req_a_i       - port A request
//               req_b_i       - port B request
//               last_owner_i  - port granted most recently
//               gnt_o[1:0]    - one-hot grant, bit 0 = A, bit 1 = B
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_rr_pick
  import data_memory_arbiter_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  port_e      last_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_a_i && req_b_i) begin
      gnt_o = (last_owner_i == PORT_B) ? 2'b01 : 2'b10;
    end else if (req_a_i) begin
      gnt_o = 2'b01;
    end else if (req_b_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule : data_memory_rr_pick

`default_nettype wire

// File: rtl/data_memory_arbiter.sv
// ============================================================================
// Module      : data_memory_arbiter
// Description : Shares the single data_memory port between the CPU
//               load/store unit (port A) and the debug/DMA loader (port B).
//               Round-robin arbitration with a bounded ownership lock;
//               one-cycle-latency read data is routed back to the port that
//               issued the read.
// Ports       : clock, reset                 - clock, async active-high reset
//               a_*/b_* req, lock, address,
//                 mem_mode, mem_unsigned,
//                 wren, data                 - requester payload (inputs)
//               a_gnt/b_gnt                  - access accepted this cycle
//               a_rvalid/b_rvalid, a_q/b_q   - read response
//               mem_address, mem_mode,
//                 mem_unsigned, mem_wren,
//                 mem_data                   - to data_memory
//               mem_q                        - from data_memory
// Parameters  : MAX_LOCK - consecutive contested grants a locking owner keeps
//               LOCK_W   - lock counter width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8,
  parameter int LOCK_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  // port A
  input  logic        a_req,
  input  logic        a_lock,
  input  logic [31:0] a_address,
  input  logic [1:0]  a_mem_mode,
  input  logic        a_mem_unsigned,
  input  logic        a_wren,
  input  logic [31:0] a_data,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_q,
  // port B
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [31:0] b_address,
  input  logic [1:0]  b_mem_mode,
  input  logic        b_mem_unsigned,
  input  logic        b_wren,
  input  logic [31:0] b_data,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_q,
  // data_memory
  output logic [31:0] mem_address,
  output logic [1:0]  mem_mode,
  output logic        mem_unsigned,
  output logic        mem_wren,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_q
);

  localparam logic [LOCK_W-1:0] c_max_lock = LOCK_W'(MAX_LOCK);
  localparam logic [LOCK_W-1:0] c_cnt_sat  = {LOCK_W{1'b1}};

  lock_state_e       state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  port_e             last_owner_q;

  logic              rsp_valid_q;
  port_e             rsp_port_q;
  logic              rsp_unsigned_q;

  logic [31:0]       a_q_hold_q, b_q_hold_q;
  logic [31:0]       addr_hold_q, data_hold_q;
  logic [1:0]        mode_hold_q;

  logic [1:0]        w_pick;
  logic              w_fsm_gnt_a, w_fsm_gnt_b;
  logic              w_gnt_a, w_gnt_b, w_any_gnt;
  logic              w_sel_wren, w_sel_unsigned;
  logic [31:0]       w_sel_addr, w_sel_data;
  logic [1:0]        w_sel_mode;

  data_memory_rr_pick u_rr_pick (
    .req_a_i      (a_req),
    .req_b_i      (b_req),
    .last_owner_i (last_owner_q),
    .gnt_o        (w_pick)
  );

  // --------------------------------------------------------------------------
  // Lock FSM / grant decision
  // The lock counter tracks grants the owner has taken while the other port
  // was waiting, so the entry grant only counts if the other port was
  // already requesting at that moment.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    w_fsm_gnt_a = 1'b0;
    w_fsm_gnt_b = 1'b0;
    case (state_q)
      LOCK_IDLE: begin
        w_fsm_gnt_a = w_pick[0];
        w_fsm_gnt_b = w_pick[1];
        if (w_pick[0] && a_lock) begin
          state_d    = LOCK_A;
          lock_cnt_d = b_req ? LOCK_W'(1) : '0;
        end else if (w_pick[1] && b_lock) begin
          state_d    = LOCK_B;
          lock_cnt_d = a_req ? LOCK_W'(1) : '0;
        end
      end
      LOCK_A: begin
        if (a_req && (!b_req || (lock_cnt_q < c_max_lock))) begin
          w_fsm_gnt_a = 1'b1;
          if (!a_lock) begin
            state_d    = LOCK_IDLE;
            lock_cnt_d = '0;
          end else if (b_req && (lock_cnt_q != c_cnt_sat)) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end else begin
          // Owner dropped its request, or the lock budget is spent while B
          // waits: hand over and fall back to round-robin.
          w_fsm_gnt_b = b_req;
          state_d     = LOCK_IDLE;
          lock_cnt_d  = '0;
        end
      end
      LOCK_B: begin
        if (b_req && (!a_req || (lock_cnt_q < c_max_lock))) begin
          w_fsm_gnt_b = 1'b1;
          if (!b_lock) begin
            state_d    = LOCK_IDLE;
            lock_cnt_d = '0;
          end else if (a_req && (lock_cnt_q != c_cnt_sat)) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end else begin
          w_fsm_gnt_a = a_req;
          state_d     = LOCK_IDLE;
          lock_cnt_d  = '0;
        end
      end
      default: begin
        state_d    = LOCK_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // No access may reach memory while reset is held.
  assign w_gnt_a   = w_fsm_gnt_a & ~reset;
  assign w_gnt_b   = w_fsm_gnt_b & ~reset;
  assign w_any_gnt = w_gnt_a | w_gnt_b;

  // --------------------------------------------------------------------------
  // Request mux; without a grant the address/mode/data hold their last value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_addr     = addr_hold_q;
    w_sel_mode     = mode_hold_q;
    w_sel_data     = data_hold_q;
    w_sel_wren     = 1'b0;
    w_sel_unsigned = 1'b0;
    if (w_gnt_a) begin
      w_sel_addr     = a_address;
      w_sel_mode     = a_mem_mode;
      w_sel_data     = a_data;
      w_sel_wren     = a_wren;
      w_sel_unsigned = a_mem_unsigned;
    end else if (w_gnt_b) begin
      w_sel_addr     = b_address;
      w_sel_mode     = b_mem_mode;
      w_sel_data     = b_data;
      w_sel_wren     = b_wren;
      w_sel_unsigned = b_mem_unsigned;
    end
  end

  assign a_gnt       = w_gnt_a;
  assign b_gnt       = w_gnt_b;
  assign mem_address = w_sel_addr;
  assign mem_mode    = w_sel_mode;
  assign mem_data    = w_sel_data;
  assign mem_wren    = w_sel_wren;

  // data_memory applies sign/zero extension while producing q, i.e. in the
  // cycle after the grant, so the flag must come from the response stage.
  assign mem_unsigned = rsp_unsigned_q;

  assign a_rvalid = rsp_valid_q && (rsp_port_q == PORT_A);
  assign b_rvalid = rsp_valid_q && (rsp_port_q == PORT_B);
  assign a_q      = a_rvalid ? mem_q : a_q_hold_q;
  assign b_q      = b_rvalid ? mem_q : b_q_hold_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= LOCK_IDLE;
      lock_cnt_q     <= '0;
      last_owner_q   <= PORT_B;
      rsp_valid_q    <= 1'b0;
      rsp_port_q     <= PORT_A;
      rsp_unsigned_q <= 1'b0;
      a_q_hold_q     <= '0;
      b_q_hold_q     <= '0;
      addr_hold_q    <= '0;
      mode_hold_q    <= '0;
      data_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= w_any_gnt && !w_sel_wren;
      if (w_any_gnt) begin
        last_owner_q <= w_gnt_a ? PORT_A : PORT_B;
        addr_hold_q  <= w_sel_addr;
        mode_hold_q  <= w_sel_mode;
        data_hold_q  <= w_sel_data;
      end
      if (w_any_gnt && !w_sel_wren) begin
        rsp_port_q     <= w_gnt_a ? PORT_A : PORT_B;
        rsp_unsigned_q <= w_sel_unsigned;
      end
      if (a_rvalid) a_q_hold_q <= mem_q;
      if (b_rvalid) b_q_hold_q <= mem_q;
    end
  end

endmodule : data_memory_arbiter

`default_nettype wire
